// File: rtl/datapath_feeder.sv
// Source stage for the encrypted-negation datapath: fetches 128-bit blocks as two 64-bit
// reads and drives them as back-to-back beats, throttled by a block-credit counter.
module datapath_feeder #(
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_blocks,
  output logic              busy,
  output logic              done,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data,
  output logic              dp_input_valid,
  output logic [63:0]       dp_input_data,
  input  logic              dp_output_valid
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_LO, S_WAIT_LO, S_REQ_HI, S_WAIT_HI,
    S_CREDIT, S_BEAT_LO, S_BEAT_HI, S_DRAIN, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [127:0]      buf_q, buf_d;
  logic [CNT_W-1:0]  infl_q, infl_d;
  logic              par_q, par_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_v_q, req_v_d;
  logic [ADDR_W-1:0] req_a_q, req_a_d;
  logic              dpv_q, dpv_d;
  logic [63:0]       dpd_q, dpd_d;
  logic              blk_issue, blk_return;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            addr_d  = base_addr;
            rem_d   = num_blocks;
            state_d = S_REQ_LO;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_REQ_LO: begin
        if (mem_req_ready) begin
          addr_d  = addr_q + ADDR_W'(8);
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (mem_resp_valid) begin
          buf_d[63:0] = mem_resp_data;
          state_d     = S_REQ_HI;
        end
      end
      S_REQ_HI: begin
        if (mem_req_ready) begin
          addr_d  = addr_q + ADDR_W'(8);
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (mem_resp_valid) begin
          buf_d[127:64] = mem_resp_data;
          state_d       = S_CREDIT;
        end
      end
      S_CREDIT:  if (infl_q < MAX_CNT) state_d = S_BEAT_LO;
      S_BEAT_LO: state_d = S_BEAT_HI;
      S_BEAT_HI: begin
        rem_d   = rem_q - LEN_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? S_DRAIN : S_REQ_LO;
      end
      S_DRAIN:   if (infl_q == '0) state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // A block is returned on the second of each pair of datapath output beats.
  always_comb begin
    blk_issue  = (state_q == S_BEAT_HI);
    blk_return = dp_output_valid && par_q;
    par_d      = par_q ^ dp_output_valid;
    infl_d     = infl_q;
    if (blk_issue && !blk_return) begin
      infl_d = infl_q + CNT_W'(1);
    end else if (!blk_issue && blk_return && (infl_q != '0)) begin
      infl_d = infl_q - CNT_W'(1);
    end
  end

  always_comb begin
    busy_d  = !((state_d == S_IDLE) || (state_d == S_FIN));
    done_d  = (state_d == S_FIN);
    req_v_d = (state_d == S_REQ_LO) || (state_d == S_REQ_HI);
    req_a_d = req_v_d ? addr_d : req_a_q;
    dpv_d   = (state_d == S_BEAT_LO) || (state_d == S_BEAT_HI);
    dpd_d   = dpd_q;
    if (state_d == S_BEAT_LO) dpd_d = buf_d[63:0];
    if (state_d == S_BEAT_HI) dpd_d = buf_d[127:64];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      infl_q  <= '0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_v_q <= 1'b0;
      req_a_q <= '0;
      dpv_q   <= 1'b0;
      dpd_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      infl_q  <= infl_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_v_q <= req_v_d;
      req_a_q <= req_a_d;
      dpv_q   <= dpv_d;
      dpd_q   <= dpd_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_req_valid  = req_v_q;
  assign mem_req_addr   = req_a_q;
  assign dp_input_valid = dpv_q;
  assign dp_input_data  = dpd_q;

endmodule

// File: tb/tb_datapath_feeder.sv
// Bench for datapath_feeder: random memory/datapath environment with an address/beat
// scoreboard and a block-level credit model.
module tb_datapath_feeder;
  localparam int MAX_INFLIGHT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_blocks = '0;
  logic        busy, done, mem_req_valid, dp_input_valid;
  logic [31:0] mem_req_addr;
  logic [63:0] dp_input_data;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        dp_output_valid = 1'b0;

  datapath_feeder #(.ADDR_W(32), .LEN_W(16), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clock(clk), .reset(rst_n), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .busy(busy), .done(done),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .dp_input_valid(dp_input_valid),
    .dp_input_data(dp_input_data), .dp_output_valid(dp_output_valid)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk = 0;
  int echo_on, echo_L, ready_pct, stall_cyc, dly_min, dly_max, manual_req, cur_n;
  int out_lag2 = 0;
  int done_seen = 0;
  int beat_cnt = 0;
  logic [63:0] dq[$];
  logic [31:0] exp_addr[$];
  logic [63:0] exp_beat[$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory responder and datapath echo; drives all inputs on the falling edge.
  initial begin : env
    bit pend;
    int pcnt, stall_left, out_cnt, lag1, man_done;
    logic [63:0] pdata;
    bit prev_valid, dpo;
    bit sh[16];
    pend = 0; pcnt = 0; stall_left = 0; out_cnt = 0; lag1 = 0; man_done = 0;
    pdata = '0; prev_valid = 0; sh = '{default: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_cnt = 0; lag1 = 0; out_lag2 = 0; man_done = manual_req;
        sh = '{default: 1'b0}; prev_valid = 0; stall_left = 0;
        dp_output_valid = 0; mem_resp_valid = 0; mem_req_ready = 0;
      end else begin
        out_lag2 = lag1;
        lag1 = out_cnt;
        mem_resp_valid = 0;
        if (pend) begin
          if (pcnt == 0) begin
            mem_resp_valid = 1; mem_resp_data = pdata; pend = 0;
          end else pcnt--;
        end
        if (mem_req_valid && !prev_valid) stall_left = stall_cyc;
        prev_valid = mem_req_valid;
        if (stall_left > 0) begin
          mem_req_ready = 0; stall_left--;
        end else begin
          mem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
        end
        if (mem_req_valid && mem_req_ready) begin
          if (dq.size() > 0) pdata = dq.pop_front();
          else pdata = {$urandom, $urandom};
          pend = 1;
          pcnt = int'($urandom_range(dly_max, dly_min)) - 1;
          exp_beat.push_back(pdata);
        end
        for (int i = 15; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = dp_input_valid;
        dpo = (echo_on != 0) && sh[echo_L-1];
        if (man_done < manual_req) begin dpo = 1; man_done++; end
        dp_output_valid = dpo;
        if (dpo) out_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request, a beat or done.
  initial begin : mon
    bit prev_lo, prev_done, prev_busy;
    logic [63:0] last_data, eb;
    logic [31:0] ea;
    int issued;
    prev_lo = 0; prev_done = 0; prev_busy = 0; last_data = '0; issued = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        exp_addr.delete(); exp_beat.delete();
        issued = 0; last_data = '0; prev_lo = 0; prev_done = 0; prev_busy = 0;
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          if (exp_addr.size() == 0) chk(0, "unexpected_req", 64'(mem_req_addr), 64'h0);
          else begin
            ea = exp_addr.pop_front();
            chk(mem_req_addr == ea, "req_addr", 64'(mem_req_addr), 64'(ea));
          end
        end
        if (prev_lo) chk(dp_input_valid, "beat_hi_consecutive", 64'(dp_input_valid), 64'h1);
        if (dp_input_valid) begin
          if (!prev_lo) begin
            chk(issued - out_lag2 / 2 < MAX_INFLIGHT, "inflight_limit",
                64'(issued - out_lag2 / 2), 64'(MAX_INFLIGHT));
            issued++;
          end
          if (exp_beat.size() == 0) chk(0, "unexpected_beat", dp_input_data, 64'h0);
          else begin
            eb = exp_beat.pop_front();
            chk(dp_input_data == eb, "beat_data", dp_input_data, eb);
          end
          last_data = dp_input_data;
          beat_cnt++;
        end else begin
          chk(dp_input_data == last_data, "data_hold", dp_input_data, last_data);
        end
        prev_lo = dp_input_valid && !prev_lo;
        if (done) begin
          done_seen++;
          chk(!busy, "busy_low_at_done", 64'(busy), 64'h0);
          chk(out_lag2 / 2 == issued, "returns_at_done", 64'(out_lag2 / 2), 64'(issued));
          if (cur_n != 0) chk(prev_busy, "busy_before_done", 64'(prev_busy), 64'h1);
        end
        if (prev_done) chk(!done, "done_single_cycle", 64'(done), 64'h0);
        prev_done = done;
        prev_busy = busy;
      end
    end
  end

  task automatic chk_reset_outputs(input string name);
    logic [3:0] ctl;
    ctl = {busy, done, mem_req_valid, dp_input_valid};
    chk(ctl == 4'b0, name, 64'(ctl), 64'h0);
    chk(mem_req_addr == '0 && dp_input_data == '0, name, {mem_req_addr, dp_input_data[31:0]}, 64'h0);
  endtask

  task automatic start_job(input logic [31:0] base, input int n);
    for (int i = 0; i < 2 * n; i++) exp_addr.push_back(32'(base + 32'(8 * i)));
    cur_n = n;
    @(negedge clk);
    start = 1; base_addr = base; num_blocks = 16'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while (done_seen == d0 && k < budget) begin @(negedge clk); #2; k++; end
    if (done_seen == d0) chk(0, "done_timeout", 64'(k), 64'(budget));
  endtask

  task automatic post_checks(input int d0);
    repeat (3) @(negedge clk);
    #2;
    chk(done_seen - d0 == 1, "done_count", 64'(done_seen - d0), 64'h1);
    chk(exp_addr.size() == 0, "addr_queue_empty", 64'(exp_addr.size()), 64'h0);
    chk(exp_beat.size() == 0, "beat_queue_empty", 64'(exp_beat.size()), 64'h0);
    chk(!busy, "idle_after_job", 64'(busy), 64'h0);
  endtask

  task automatic run_job(input logic [31:0] base, input int n);
    int d0;
    d0 = done_seen;
    start_job(base, n);
    wait_done(d0, 1500);
    post_checks(d0);
  endtask

  initial begin : stim
    int d0, b0, first;
    bit saw_req, saw_beat;
    logic [31:0] r;
    echo_on = 1; echo_L = 3; ready_pct = 100; stall_cyc = 0;
    dly_min = 1; dly_max = 1; manual_req = 0; cur_n = 0;

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset_state");
    #2 rst_n = 1;

    dq.push_back(64'h1111_2222_3333_4444);
    dq.push_back(64'h5555_6666_7777_8888);
    run_job(32'h0000_0100, 1);

    d0 = done_seen; saw_req = 0; first = 0; cur_n = 0;
    @(negedge clk);
    start = 1; base_addr = 32'h40; num_blocks = 16'd0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 0;
      #2;
      if (mem_req_valid) saw_req = 1;
      if (done_seen != d0 && first == 0) first = k;
    end
    chk(!saw_req, "zero_no_req", 64'(saw_req), 64'h0);
    chk(first >= 1 && first <= 2, "zero_done_latency", 64'(first), 64'h2);
    chk(done_seen - d0 == 1, "zero_done_count", 64'(done_seen - d0), 64'h1);

    echo_on = 0;
    d0 = done_seen; b0 = beat_cnt;
    start_job(32'h0000_2000, 4);
    repeat (80) @(negedge clk);
    #2;
    chk(beat_cnt - b0 == 4, "stall_beats", 64'(beat_cnt - b0), 64'h4);
    chk(busy, "stall_busy", 64'(busy), 64'h1);
    chk(done_seen == d0, "stall_no_done", 64'(done_seen - d0), 64'h0);
    manual_req += 2;
    repeat (80) @(negedge clk);
    #2;
    chk(beat_cnt - b0 == 6, "one_more_block", 64'(beat_cnt - b0), 64'h6);
    manual_req += 6;
    wait_done(d0, 500);
    post_checks(d0);
    echo_on = 1;

    run_job(32'hFFFF_FFF8, 2);

    ready_pct = 70; dly_min = 1; dly_max = 3;
    for (int L = 1; L <= 10; L++) begin
      echo_L = L;
      r = $urandom;
      run_job({r[31:3], 3'b000}, int'($urandom_range(4, 1)));
    end

    ready_pct = 100; stall_cyc = 5; dly_min = 7; dly_max = 7; echo_L = 4;
    d0 = done_seen;
    start_job(32'h0000_3000, 3);
    repeat (20) @(negedge clk);
    chk(busy, "busy_before_second_start", 64'(busy), 64'h1);
    start = 1; base_addr = 32'hDEAD_0000; num_blocks = 16'd5;
    @(negedge clk);
    start = 0;
    wait_done(d0, 1500);
    post_checks(d0);
    stall_cyc = 0; dly_min = 6; dly_max = 6;

    start_job(32'h0000_5000, 3);
    repeat (12) @(negedge clk);
    #3 rst_n = 0;
    #1 chk_reset_outputs("reset_async");
    repeat (3) begin
      @(negedge clk);
      #1 chk_reset_outputs("reset_hold");
    end
    #2 rst_n = 1;
    d0 = done_seen; saw_req = 0; saw_beat = 0;
    repeat (12) begin
      @(negedge clk);
      #2;
      if (mem_req_valid) saw_req = 1;
      if (dp_input_valid) saw_beat = 1;
    end
    chk(!saw_req, "post_reset_no_req", 64'(saw_req), 64'h0);
    chk(!saw_beat, "post_reset_no_beat", 64'(saw_beat), 64'h0);
    chk(done_seen == d0, "post_reset_no_done", 64'(done_seen - d0), 64'h0);

    dly_min = 1; dly_max = 2; echo_L = 2;
    run_job(32'h0000_6000, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the summary, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
